// File: rtl/icache_axi_refill_pkg.sv
// Shared definitions for the instruction-cache AXI refill engine:
// FSM state encoding, AXI field constants and line-address helpers.
package icache_axi_refill_pkg;

  typedef enum logic [2:0] {
    ICACHE_REFILL_STATE_IDLE = 3'd0,
    ICACHE_REFILL_STATE_ADDR = 3'd1,
    ICACHE_REFILL_STATE_DATA = 3'd2,
    ICACHE_REFILL_STATE_LAST = 3'd3,
    ICACHE_REFILL_STATE_DONE = 3'd4
  } refill_state_e;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam int         ICACHE_LINE_BEATS = 4;

  // Align a byte address to the start of its 16-byte cache line.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:4], 4'b0000};
  endfunction

endpackage

// File: rtl/icache_axi_refill.sv
// Refill engine: turns one line request from the I-cache controller into a
// single 4-beat AXI4 INCR read burst, forwards every beat with its word
// offset and closes each transaction with a one-cycle done pulse.
module icache_axi_refill
  import icache_axi_refill_pkg::*;
#(
  parameter logic [3:0] ID_VALUE = 4'h0,
  parameter int         BEATS    = ICACHE_LINE_BEATS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] refill_addr,
  input  logic        refill_start,
  output logic        refill_busy,
  output logic        refill_done,
  output logic [31:0] refill_data,
  output logic [1:0]  refill_word,
  output logic        refill_data_valid,
  output logic        refill_error,
  output logic [3:0]  m_axi_arid,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [3:0]  m_axi_rid,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  refill_state_e state_r;
  logic [1:0]    beat_cnt_r;
  logic [31:0]   araddr_r;
  logic          arvalid_r;
  logic          rready_r;
  logic          busy_r;
  logic          done_r;
  logic [31:0]   data_r;
  logic [1:0]    word_r;
  logic          data_valid_r;
  logic          error_r;
  logic          beat_hs_s;
  logic          beat_bad_s;
  logic          unused_s;

  // The read ID is not checked and the byte offset within a line is irrelevant.
  assign unused_s = ^{m_axi_rid, refill_addr[3:0]};

  // A beat is accepted on the R handshake; it is flagged bad on a non-OKAY
  // response or when rlast disagrees with the beat counter.
  assign beat_hs_s  = rready_r & m_axi_rvalid;
  assign beat_bad_s = (m_axi_rresp != AXI_RESP_OKAY) |
                      (m_axi_rlast != (beat_cnt_r == LAST_BEAT));

  // Refill FSM with all outputs registered; the beat counter alone decides
  // when the burst ends, so exactly BEATS beats are always consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ICACHE_REFILL_STATE_IDLE;
      beat_cnt_r   <= 2'd0;
      araddr_r     <= 32'd0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      data_r       <= 32'd0;
      word_r       <= 2'd0;
      data_valid_r <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        ICACHE_REFILL_STATE_IDLE: begin
          if (refill_start) begin
            state_r    <= ICACHE_REFILL_STATE_ADDR;
            araddr_r   <= line_align(refill_addr);
            beat_cnt_r <= 2'd0;
            error_r    <= 1'b0;
            arvalid_r  <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        ICACHE_REFILL_STATE_ADDR: begin
          if (arvalid_r && m_axi_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= ICACHE_REFILL_STATE_DATA;
          end
        end
        ICACHE_REFILL_STATE_DATA: begin
          if (beat_hs_s) begin
            data_r       <= m_axi_rdata;
            word_r       <= beat_cnt_r;
            data_valid_r <= 1'b1;
            beat_cnt_r   <= beat_cnt_r + 2'd1;
            if (beat_bad_s) begin
              error_r <= 1'b1;
            end
            if (beat_cnt_r == LAST_BEAT) begin
              rready_r <= 1'b0;
              state_r  <= ICACHE_REFILL_STATE_LAST;
            end
          end
        end
        ICACHE_REFILL_STATE_LAST: begin
          done_r  <= 1'b1;
          state_r <= ICACHE_REFILL_STATE_DONE;
        end
        ICACHE_REFILL_STATE_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ICACHE_REFILL_STATE_IDLE;
        end
        default: begin
          state_r   <= ICACHE_REFILL_STATE_IDLE;
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign refill_busy       = busy_r;
  assign refill_done       = done_r;
  assign refill_data       = data_r;
  assign refill_word       = word_r;
  assign refill_data_valid = data_valid_r;
  assign refill_error      = error_r;

  assign m_axi_arid    = ID_VALUE;
  assign m_axi_araddr  = araddr_r;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed bench for icache_axi_refill: a table of refill scenarios driven
// through a scripted AXI read slave, plus hand-written reset sequences.
module tb_icache_axi_refill;

  logic        clk;
  logic        rst;
  logic [31:0] refill_addr;
  logic        refill_start;
  logic        refill_busy;
  logic        refill_done;
  logic [31:0] refill_data;
  logic [1:0]  refill_word;
  logic        refill_data_valid;
  logic        refill_error;
  logic [3:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [3:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  int n_cmp = 0;
  int n_err = 0;

  icache_axi_refill dut (
    .clk               (clk),
    .rst               (rst),
    .refill_addr       (refill_addr),
    .refill_start      (refill_start),
    .refill_busy       (refill_busy),
    .refill_done       (refill_done),
    .refill_data       (refill_data),
    .refill_word       (refill_word),
    .refill_data_valid (refill_data_valid),
    .refill_error      (refill_error),
    .m_axi_arid        (m_axi_arid),
    .m_axi_araddr      (m_axi_araddr),
    .m_axi_arlen       (m_axi_arlen),
    .m_axi_arsize      (m_axi_arsize),
    .m_axi_arburst     (m_axi_arburst),
    .m_axi_arvalid     (m_axi_arvalid),
    .m_axi_arready     (m_axi_arready),
    .m_axi_rid         (m_axi_rid),
    .m_axi_rdata       (m_axi_rdata),
    .m_axi_rresp       (m_axi_rresp),
    .m_axi_rlast       (m_axi_rlast),
    .m_axi_rvalid      (m_axi_rvalid),
    .m_axi_rready      (m_axi_rready)
  );

  // Free-running core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;       // requested address
    logic [31:0] base;       // beat n returns base + n
    int          ar_delay;   // cycles arready stays low while arvalid is high
    int          gap_after;  // beat index after which rvalid drops (7 = never)
    int          gap_len;    // length of that rvalid gap
    int          err_beat;   // beat returning SLVERR (7 = none)
    logic [3:0]  rlast_mask; // rlast value per beat index
    int          hold;       // cycles refill_start stays high
    logic [31:0] exp_araddr;
    logic        exp_err;
    int          exp_lat;    // start-to-done cycles
  } vec_t;

  vec_t vecs[7];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One full refill against a scripted slave; start is sampled at the end of cycle 0.
  task automatic run_refill(input vec_t v, input string tag);
    int ar_seen  = 0;
    int ar_hs    = 0;
    int sb       = 0;
    int gap_cnt  = 0;
    int exp_word = 0;
    int dv_cnt   = 0;
    int done_cyc = -1;
    int last_dv  = -2;
    refill_addr  = v.addr;
    refill_start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc >= v.hold) refill_start = 1'b0;
      if (cyc == 1) begin
        check1({tag, " busy_rise"}, refill_busy, 1'b1);
        check1({tag, " error_cleared"}, refill_error, 1'b0);
      end
      m_axi_arready = 1'b0;
      if (m_axi_arvalid) begin
        ar_seen++;
        check32({tag, " araddr"}, m_axi_araddr, v.exp_araddr);
        m_axi_arready = (ar_seen > v.ar_delay);
        if (m_axi_arready) begin
          ar_hs++;
          check32({tag, " arlen"}, {24'd0, m_axi_arlen}, 32'd3);
          check32({tag, " arsize_burst"}, {27'd0, m_axi_arsize, m_axi_arburst}, 32'b010_01);
        end
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
      if (m_axi_rready && sb < 4) begin
        if (gap_cnt > 0) begin
          gap_cnt--;
        end else begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = v.base + 32'(sb);
          m_axi_rresp  = (sb == v.err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = v.rlast_mask[sb];
          if (sb == v.gap_after) gap_cnt = v.gap_len;
          sb++;
        end
      end
      if (refill_data_valid) begin
        check32({tag, " data"}, refill_data, v.base + 32'(exp_word));
        check32({tag, " word"}, {30'd0, refill_word}, 32'(exp_word % 4));
        exp_word++;
        dv_cnt++;
        last_dv = cyc;
      end
      if (refill_done) begin
        done_cyc = cyc;
        break;
      end
    end
    refill_start  = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    check32({tag, " done_latency"}, 32'(done_cyc), 32'(v.exp_lat));
    check32({tag, " beat_count"}, 32'(dv_cnt), 32'd4);
    check32({tag, " done_after_last_dv"}, 32'(done_cyc), 32'(last_dv + 1));
    check32({tag, " ar_handshakes"}, 32'(ar_hs), 32'd1);
    check32({tag, " beats_consumed"}, 32'(sb), 32'd4);
    check1({tag, " error"}, refill_error, v.exp_err);
    @(posedge clk);
    #1;
    check1({tag, " busy_fall"}, refill_busy, 1'b0);
    check1({tag, " done_one_cycle"}, refill_done, 1'b0);
    check1({tag, " no_second_ar"}, m_axi_arvalid, 1'b0);
    check1({tag, " error_sticky"}, refill_error, v.exp_err);
  endtask

  // Main sequence: reset checks, table-driven refills, reset mid-burst.
  initial begin
    rst           = 1'b1;
    refill_addr   = 32'd0;
    refill_start  = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rid     = 4'h0;
    m_axi_rdata   = 32'd0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;

    vecs[0] = '{32'h0000_1238, 32'h0000_00A0, 0, 7, 0, 7, 4'b1000, 1, 32'h0000_1230, 1'b0, 7};
    vecs[1] = '{32'h8000_00FC, 32'hDEAD_0000, 5, 1, 3, 7, 4'b1000, 1, 32'h8000_00F0, 1'b0, 15};
    vecs[2] = '{32'h4444_4444, 32'h1234_5670, 0, 7, 0, 2, 4'b1000, 1, 32'h4444_4440, 1'b1, 7};
    vecs[3] = '{32'h0000_0010, 32'h0BAD_0000, 0, 7, 0, 7, 4'b1010, 1, 32'h0000_0010, 1'b1, 7};
    vecs[4] = '{32'hFFFF_FFFF, 32'h5555_0000, 0, 7, 0, 7, 4'b0000, 1, 32'hFFFF_FFF0, 1'b1, 7};
    vecs[5] = '{32'h0001_0004, 32'h7700_0000, 1, 0, 1, 7, 4'b1000, 1, 32'h0001_0000, 1'b0, 9};
    vecs[6] = '{32'h2000_0020, 32'h0000_0C00, 0, 7, 0, 7, 4'b1000, 3, 32'h2000_0020, 1'b0, 7};

    repeat (3) @(posedge clk);
    #1;
    check1("rst busy", refill_busy, 1'b0);
    check1("rst done", refill_done, 1'b0);
    check1("rst data_valid", refill_data_valid, 1'b0);
    check1("rst error", refill_error, 1'b0);
    check1("rst arvalid", m_axi_arvalid, 1'b0);
    check1("rst rready", m_axi_rready, 1'b0);
    check32("rst araddr", m_axi_araddr, 32'd0);
    check32("rst data_word", {refill_data[29:0], refill_word}, 32'd0);
    check32("rst arid_arlen", {20'd0, m_axi_arid, m_axi_arlen}, 32'h0000_0003);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_refill(vecs[i], $sformatf("vec%0d", i));
    end

    refill_addr  = 32'h0000_2000;
    refill_start = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk);
      #1;
      refill_start  = 1'b0;
      m_axi_arready = 1'b1;
      m_axi_rvalid  = m_axi_rready;
      m_axi_rdata   = 32'h0000_00C0 + 32'(cyc);
      m_axi_rlast   = 1'b0;
    end
    @(posedge clk);
    #1;
    check1("midrst beat1 valid", refill_data_valid, 1'b1);
    check32("midrst beat1 word", {30'd0, refill_word}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check1("midrst busy", refill_busy, 1'b0);
    check1("midrst arvalid", m_axi_arvalid, 1'b0);
    check1("midrst rready", m_axi_rready, 1'b0);
    check1("midrst data_valid", refill_data_valid, 1'b0);
    check1("midrst done", refill_done, 1'b0);
    check32("midrst data", refill_data, 32'd0);
    rst           = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    @(posedge clk);
    #1;
    run_refill(vecs[0], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_axi_refill.md
# icache_axi_refill

Refill engine for the instruction cache. It accepts a one-line refill request from `icache_controller` (`refill_start` / `refill_addr`) and issues a single AXI4 INCR read burst of 4 × 32-bit beats. It returns each beat to the controller as `refill_data` / `refill_word` / `refill_data_valid` and closes the transaction with a `refill_done` pulse. It sits between the I-cache controller and the instruction-side AXI master port of the interconnect.

## Interface
Parameters:
- `ID_VALUE`, default 4'h0: constant driven on `m_axi_arid`.
- `BEATS`, default 4: beats per line, fixed at 4 to match the 16-byte line.

Ports:
- `clk`  in  1  core clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `refill_addr`  in  32  line address; bits [3:0] are ignored.
- `refill_start`  in  1  request; sampled only in IDLE; may be held high for several cycles.
- `refill_busy`  out  1  high in every state except IDLE.
- `refill_done`  out  1  one-cycle completion pulse.
- `refill_data`  out  32  returned beat data.
- `refill_word`  out  2  word offset of `refill_data` within the line.
- `refill_data_valid`  out  1  one-cycle strobe per beat.
- `refill_error`  out  1  sticky error: set on any beat with nonzero RRESP or on an rlast/beat-count mismatch; cleared on the next accepted start.
- `m_axi_arid`  out  4
- `m_axi_araddr`  out  32
- `m_axi_arlen`  out  8
- `m_axi_arsize`  out  3
- `m_axi_arburst`  out  2
- `m_axi_arvalid`  out  1
- `m_axi_arready`  in  1
- `m_axi_rid`  in  4  ignored.
- `m_axi_rdata`  in  32
- `m_axi_rresp`  in  2
- `m_axi_rlast`  in  1
- `m_axi_rvalid`  in  1
- `m_axi_rready`  out  1

## Operation
- States: IDLE, ADDR, DATA, LAST, DONE.
- IDLE → ADDR when `refill_start`=1. On that transition, latch `araddr` = {`refill_addr`[31:4], 4'b0}, clear the beat counter, clear `refill_error`.
- ADDR:
  - `arvalid`=1.
  - `araddr` stays stable until the handshake.
  - `arlen`=3, `arsize`=3'b010, `arburst`=INCR.
  - On `arvalid` && `arready`, go to DATA.
- DATA:
  - `rready`=1.
  - On each `rvalid` && `rready` handshake, register `refill_data`=`rdata` and `refill_word`=beat counter, pulse `refill_data_valid` the following cycle, then increment the counter (2-bit, wraps 3→0).
  - When the beat counter is 3, go to LAST.
  - Error conditions that set `refill_error`:
    - `rresp`≠OKAY on any beat.
    - `rlast`=1 on a beat other than 3.
    - `rlast`=0 on beat 3.
  - The counter is authoritative: exactly 4 beats are always consumed.
- LAST: carries the `refill_data_valid` for word 3. Unconditionally go to DONE.
- DONE: `refill_done`=1 for one cycle, then go to IDLE.
  - `refill_done` therefore follows the final `refill_data_valid` by exactly one cycle. The controller's registered capture of the requested word is complete before it samples `refill_done`.
- `refill_start` seen outside IDLE is ignored. This covers the controller's start pulse still being registered after `busy` rises.
- A started burst is never cancelled. It always ends with `refill_done`, including after an error.
- Beat data is forwarded even when `rresp` is an error.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `data_valid`, `error`, `arvalid`, `rready` = 0.
  - `araddr`, `refill_data` = 0; `refill_word` = 0.
  - `arid`/`arlen`/`arsize`/`arburst` are constants.
- Reset mid-burst returns to IDLE next edge with all outputs at reset values. The interconnect is reset together with this block.
- Best case (`arready`, `rvalid` always 1), with `start` sampled at the end of cycle 0:
  - ADDR in cycle 1.
  - DATA cycles 2–5: one beat per cycle.
  - `data_valid` for words 0–3 in cycles 3–6 (LAST = cycle 6).
  - `done` in cycle 7; IDLE in cycle 8.
  - Start-to-done: 7 cycles.
- `refill_busy` rises the cycle after `start` is sampled. It falls the cycle after `done`.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE.
- Throughput: one beat per cycle; `rvalid` gaps stall without dropping beats.

## Structure
- Add to `icache_defines.vh`:
  - `ICACHE_REFILL_STATE_{IDLE,ADDR,DATA,LAST,DONE}` (3-bit).
  - `AXI_BURST_INCR`=2'b01.
  - `AXI_SIZE_4B`=3'b010.
  - `AXI_RESP_OKAY`=2'b00.
  - `ICACHE_LINE_BEATS`=4.
- Single flat module; no sub-module is warranted.

## Test plan
- **Basic refill.** Stimulus: `refill_addr`=0x0000_1238, zero-wait slave returning 0xA0..0xA3. Required: `araddr`=0x0000_1230, `arlen`=3; `data_valid` on words 0,1,2,3 with matching data; `done` exactly 7 cycles after `start`; `error`=0.
- **Backpressure.** Stimulus: `arready` delayed 5 cycles; `rvalid` gap of 3 cycles after beat 1. Required: `arvalid`/`araddr` held stable through the delay; 4 beats in order; `done` one cycle after last `data_valid`.
- **Held start.** Stimulus: `refill_start` held high for 3 cycles. Required: exactly one AR handshake; no second burst.
- **Error response.** Stimulus: `rresp`=SLVERR on beat 2. Required: all 4 beats forwarded; `done` pulses; `error`=1 until the next start, where it clears.
- **rlast mismatch.** Stimulus: `rlast` asserted on beat 1. Required: `error`=1; the block still consumes 4 beats before `done`.
- **Reset mid-burst.** Stimulus: `rst`=1 after beat 1. Required: next cycle `busy`, `arvalid`, `rready`, `data_valid`, `done` = 0; a fresh `start` completes normally.
